// File: rtl/wide_sort_loader_if.sv
// ---------------------------------------------------------------------------
// wide_sort_loader_if
// Purpose : bundles the serial element input channel and the wide frame
//           output channel of the wide sort loader.
// Signals : InData/InValid/InLast/InReady  - serial element stream
//           X/XCount/XValid/XReady          - assembled frame towards sorter
// Modports: master - the loader itself (drives InReady and the frame)
//           slave  - the environment (drives elements and XReady)
// ---------------------------------------------------------------------------
interface wide_sort_loader_if #(
  parameter int N = 4,
  parameter int M = 5
);
  localparam int CW = $clog2(M + 1);

  logic [N-1:0]  InData;
  logic          InValid;
  logic          InLast;
  logic          InReady;
  logic [N-1:0]  X [M-1:0];
  logic [CW-1:0] XCount;
  logic          XValid;
  logic          XReady;

  modport master (
    input  InData, InValid, InLast, XReady,
    output InReady, X, XCount, XValid
  );

  modport slave (
    output InData, InValid, InLast, XReady,
    input  InReady, X, XCount, XValid
  );
endinterface

// File: rtl/wide_sort_loader.sv
// ---------------------------------------------------------------------------
// wide_sort_loader
// Purpose : collects a serial stream of N-bit elements into frames of M
//           slots for a wide sorter. A frame closes after M elements or on
//           an element flagged InLast; unused slots are filled with PAD.
//           A closed frame that cannot enter the output register yet is
//           parked internally and input is stalled until it moves on.
// Ports   : Clk   - single clock, rising edge
//           Reset - asynchronous, active-low reset
//           bus   - wide_sort_loader_if.master (element in, frame out)
// ---------------------------------------------------------------------------
module wide_sort_loader #(
  parameter int          N   = 4,
  parameter int          M   = 5,
  parameter int unsigned PAD = 2**N - 1
) (
  input  logic               Clk,
  input  logic               Reset,
  wide_sort_loader_if.master bus
);

  localparam int IW = $clog2(M);
  localparam int CW = $clog2(M + 1);

  typedef enum logic {
    FILL,
    PENDING
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  buf_q [M-1:0];
  logic [N-1:0]  buf_d [M-1:0];
  logic [CW-1:0] holdCount_q, holdCount_d;
  logic [N-1:0]  x_q [M-1:0];
  logic [N-1:0]  x_d [M-1:0];
  logic [CW-1:0] xCount_q, xCount_d;
  logic          xValid_q, xValid_d;

  logic          inReady;
  logic          accept;
  logic          closeFrame;
  logic          outFree;
  logic [N-1:0]  closed [M-1:0];
  logic [CW-1:0] closedCount;

  // Input is only offered while collecting and never while reset is held.
  assign inReady     = (state_q == FILL) && Reset;
  assign bus.InReady = inReady;
  assign bus.X       = x_q;
  assign bus.XCount  = xCount_q;
  assign bus.XValid  = xValid_q;

  // The closing frame is assembled on the fly: already stored slots, the
  // element arriving this cycle, and PAD beyond it. This lets a frame reach
  // the output register on the very edge it closes.
  always_comb begin
    accept      = bus.InValid && inReady;
    closeFrame  = accept && (bus.InLast || (idx_q == IW'(M - 1)));
    outFree     = !xValid_q || bus.XReady;
    closedCount = CW'(idx_q) + CW'(1);
    for (int i = 0; i < M; i++) begin
      if (i < int'(idx_q)) begin
        closed[i] = buf_q[i];
      end else if (i == int'(idx_q)) begin
        closed[i] = bus.InData;
      end else begin
        closed[i] = N'(PAD);
      end
    end
  end

  // Next-state logic. The collection buffer doubles as the parking place
  // for a closed frame in PENDING, since no element is accepted there.
  // A consumed output frame is dropped unless a new one replaces it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    holdCount_d = holdCount_q;
    x_d         = x_q;
    xCount_d    = xCount_q;
    xValid_d    = xValid_q && !bus.XReady;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          buf_d[idx_q] = bus.InData;
          if (closeFrame) begin
            idx_d = '0;
            if (outFree) begin
              x_d      = closed;
              xCount_d = closedCount;
              xValid_d = 1'b1;
            end else begin
              buf_d       = closed;
              holdCount_d = closedCount;
              state_d     = PENDING;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PENDING: begin
        if (bus.XReady) begin
          x_d      = buf_q;
          xCount_d = holdCount_q;
          xValid_d = 1'b1;
          state_d  = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers; reset discards any partial or parked frame and
  // clears the visible output immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      holdCount_q <= '0;
      xCount_q    <= '0;
      xValid_q    <= 1'b0;
      for (int i = 0; i < M; i++) begin
        buf_q[i] <= '0;
        x_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      holdCount_q <= holdCount_d;
      x_q         <= x_d;
      xCount_q    <= xCount_d;
      xValid_q    <= xValid_d;
    end
  end

endmodule

// File: tb/tb_wide_sort_loader.sv
// ---------------------------------------------------------------------------
// tb_wide_sort_loader
// Purpose : self-checking bench for wide_sort_loader. Stimulus tasks drive
//           the element stream and XReady; a monitor keeps a frame-level
//           reference (partial frame plus queue of closed, unconsumed
//           frames) and compares the DUT outputs against it every cycle.
// ---------------------------------------------------------------------------
module tb_wide_sort_loader;

  localparam int          N   = 4;
  localparam int          M   = 5;
  localparam int unsigned PAD = 2**N - 1;
  localparam int          CW  = $clog2(M + 1);

  typedef struct packed {
    logic [M-1:0][N-1:0] d;
    logic [CW-1:0]       cnt;
  } frame_t;

  logic Clk;
  logic Reset;
  logic randReady;
  int   checks;
  int   errors;

  frame_t       expQ [$];
  logic [N-1:0] part [$];

  wide_sort_loader_if #(.N(N), .M(M)) bus ();

  wide_sort_loader #(.N(N), .M(M), .PAD(PAD)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single comparison with pass/fail accounting.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle. Outputs are compared
  // against the model state left by the previous edge; then the model is
  // advanced by what the coming edge will do. At most two frames can be in
  // flight (one shown, one parked), so input is refused when two are queued.
  always @(negedge Clk) begin
    logic expAccept;
    if (!Reset) begin
      checkOutput("rst_xvalid", 64'(bus.XValid), 64'(0));
      checkOutput("rst_xcount", 64'(bus.XCount), 64'(0));
      checkOutput("rst_inready", 64'(bus.InReady), 64'(0));
      for (int i = 0; i < M; i++) begin
        checkOutput("rst_x", 64'(bus.X[i]), 64'(0));
      end
      expQ.delete();
      part.delete();
    end else begin
      checkOutput("in_ready", 64'(bus.InReady), 64'(expQ.size() < 2));
      checkOutput("x_valid", 64'(bus.XValid), 64'(expQ.size() > 0));
      if (expQ.size() > 0) begin
        checkOutput("x_count", 64'(bus.XCount), 64'(expQ[0].cnt));
        for (int i = 0; i < M; i++) begin
          checkOutput("x_slot", 64'(bus.X[i]), 64'(expQ[0].d[i]));
        end
      end
      expAccept = bus.InValid && (expQ.size() < 2);
      if (expQ.size() > 0 && bus.XReady) begin
        void'(expQ.pop_front());
      end
      if (expAccept) begin
        part.push_back(bus.InData);
        if (bus.InLast || part.size() == M) begin
          frame_t f;
          f.cnt = CW'(part.size());
          for (int i = 0; i < M; i++) begin
            f.d[i] = (i < part.size()) ? part[i] : N'(PAD);
          end
          expQ.push_back(f);
          part.delete();
        end
      end
    end
  end

  // Advance one cycle, reporting whether the element offered was taken.
  task automatic stepCycle(output logic accepted);
    @(negedge Clk);
    accepted = bus.InValid && bus.InReady;
    @(posedge Clk);
    #1;
    if (randReady) begin
      bus.XReady = 1'($urandom_range(0, 1));
    end
  endtask

  // Idle for gap cycles with garbage on InData/InLast, then offer one
  // element until it is accepted (bounded).
  task automatic applyStimulus(input logic [N-1:0] data, input logic last, input int gap);
    logic acc;
    for (int g = 0; g < gap; g++) begin
      bus.InValid = 1'b0;
      bus.InData  = N'($urandom);
      bus.InLast  = 1'($urandom);
      stepCycle(acc);
    end
    bus.InValid = 1'b1;
    bus.InData  = data;
    bus.InLast  = last;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      stepCycle(acc);
    end
    if (!acc) begin
      checkOutput("accept_timeout", 64'(0), 64'(1));
    end
    bus.InValid = 1'b0;
    bus.InLast  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    bus.InValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      stepCycle(acc);
    end
  endtask

  task automatic applyReset(input int n);
    @(posedge Clk);
    #1;
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    idleCycles(n);
    Reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seqA [5];
    seqA = '{4'd15, 4'd1, 4'd7, 4'd3, 4'd0};
    checks      = 0;
    errors      = 0;
    randReady   = 1'b0;
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = '0;
    bus.InLast  = 1'b0;
    bus.XReady  = 1'b0;
    idleCycles(3);
    Reset = 1'b1;

    // Back-to-back full frame with the output always free.
    bus.XReady = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(seqA[i], 1'b0, 0);
    // Short frame closed by InLast.
    applyStimulus(4'd9, 1'b0, 0);
    applyStimulus(4'd4, 1'b1, 0);
    idleCycles(2);

    // Output stalled: second frame parks and input stalls until a pulse.
    bus.XReady = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(N'(i), 1'b0, 0);
    idleCycles(3);
    bus.XReady = 1'b1;
    idleCycles(1);
    bus.XReady = 1'b0;
    idleCycles(3);
    bus.XReady = 1'b1;
    idleCycles(2);

    // Reset in the middle of a frame, then a clean frame of 2s.
    for (int i = 0; i < 3; i++) applyStimulus(4'd6, 1'b0, 0);
    applyReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(4'd2, 1'b0, 0);
    idleCycles(2);

    // InValid toggling every other cycle.
    for (int i = 0; i < 5; i++) applyStimulus(seqA[i], 1'b0, 1);
    idleCycles(2);

    // Randomized stream with random backpressure.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(N'($urandom), 1'($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    applyStimulus(N'($urandom), 1'b1, 0);
    randReady  = 1'b0;
    bus.XReady = 1'b1;
    idleCycles(4);
    @(negedge Clk);
    checkOutput("drain_xvalid", 64'(bus.XValid), 64'(0));
    checkOutput("drain_queue", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_sort_loader.md
WIDE_SORT_LOADER -- requirements
Module: wide_sort_loader

Interface
REQ-001 SHALL have parameter N, default 4, bit width of one element.
REQ-002 SHALL have parameter M, default 5, number of elements per frame (M >= 2).
REQ-003 SHALL have parameter PAD, default 2**N-1, fill value for unused slots of a short frame.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 InData  input  N  serial element.
REQ-007 InValid  input  1  InData valid.
REQ-008 InLast  input  1  qualifies the current element as the last of a short frame.
REQ-009 InReady  output  1  loader accepts an element this cycle.
REQ-010 X  output  N x M unpacked array [M-1:0]  assembled frame feeding the wide sorter X port.
REQ-011 XCount  output  $clog2(M+1)  number of real (non-pad) elements in X.
REQ-012 XValid  output  1  X/XCount hold a valid frame.
REQ-013 XReady  input  1  downstream consumes the frame this cycle.

Function
REQ-014 An element SHALL be accepted on a rising edge where InValid && InReady.
REQ-015 Accepted elements SHALL be stored in arrival order: first element to slot 0, k-th element to slot k-1.
REQ-016 A frame SHALL close on acceptance of the M-th element, or on acceptance of any element with InLast=1; InLast on the M-th element is a normal close.
REQ-017 On close, slots not written SHALL hold PAD and XCount SHALL equal the number of accepted elements (1..M).
REQ-018 Internal states: FILL (collecting) and PENDING (closed frame waiting for the output register); reset state FILL.
REQ-019 Output register is free on an edge when XValid==0 or XReady==1.
REQ-020 FILL, close edge, output free: frame SHALL load into X/XCount; XValid=1 the next cycle; fill index returns to 0; state stays FILL.
REQ-021 FILL, close edge, output not free: frame SHALL be held internally; state goes to PENDING.
REQ-022 PENDING: InReady SHALL be 0; on the first edge with XReady=1 the held frame loads into X; XValid stays 1; state returns to FILL.
REQ-023 InReady SHALL be 1 in FILL and 0 in PENDING or while Reset is low.
REQ-024 While XValid=1 and XReady=0, X, XCount and XValid SHALL be held stable.
REQ-025 XReady=1 with no new frame loading SHALL clear XValid on that edge.
REQ-026 The loader SHALL give end-to-end latency of 1 cycle, from the closing accept edge to XValid high, when the output is free.
REQ-027 Throughput SHALL be one element per cycle, with no bubble between frames when XReady is held high.
REQ-028 InData and InLast SHALL be ignored when InValid=0; XReady SHALL be ignored when XValid=0.

Reset
REQ-029 Reset low SHALL immediately force X all slots 0, XCount=0 and XValid=0.
REQ-030 Reset low SHALL also force state FILL, fill index 0 and InReady=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame and any PENDING frame; the first accept after release goes to slot 0.
REQ-032 InReady SHALL be 1 on the first cycle after Reset is released.

Verification
REQ-033 Reset, XReady=1, stream 15,1,7,3,0 back-to-back.
  -> One cycle after 5th accept: X[0..4]=15,1,7,3,0; XCount=5; XValid high one cycle.
REQ-034 Stream 9 then 4 with InLast=1.
  -> X[0]=9, X[1]=4, X[2..4]=15; XCount=2.
REQ-035 XReady=0, stream 10 elements 0..9.
  -> X=0..4 held; InReady drops after 10th accept (PENDING).
  -> Pulse XReady: X=5..9 next cycle with XValid continuously high; InReady=1.
REQ-036 Frame B closes on the same edge frame A is consumed (XReady=1).
  -> X switches A->B with no XValid gap; no element lost.
REQ-037 Accept 3 elements, assert Reset, release, stream 2,2,2,2,2.
  -> Outputs 0 during reset; resulting frame all 2s, XCount=5.
REQ-038 InValid toggling every other cycle with values of REQ-033.
  -> Same X/XCount as REQ-033; no spurious accepts.
